// File: rtl/gate_op_arbiter_if.sv
// gate_op_arbiter_if: request/grant/result bundle between the requesters and
// the gate_op_arbiter.
//
// Handshake: requester i raises req[i] with op/a_in/b_in for its slot and holds
// them stable until it sees gnt[i]. The arbiter latches them at the grant edge,
// so the requester may change or drop them from the gnt cycle onwards.
// done pulses for one cycle with result/done_id valid. result and done_id then
// hold until the next done.
//
// Signals:
//   req     [N_REQ]      request level per requester
//   op      [2*N_REQ]    op code per requester (00 OR, 01 AND, 10 NOT a, 11 NAND)
//   a_in    [W*N_REQ]    operand A per requester
//   b_in    [W*N_REQ]    operand B per requester (ignored for NOT)
//   gnt     [N_REQ]      one-hot grant, one cycle
//   done    1            result valid pulse
//   done_id [clog2 N]    requester the result belongs to
//   result  [W]          registered result
//   busy    1            arbiter is not idle
interface gate_op_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 8
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] op;
  logic [W*N_REQ-1:0] a_in;
  logic [W*N_REQ-1:0] b_in;
  logic [N_REQ-1:0]   gnt;
  logic               done;
  logic [ID_W-1:0]    done_id;
  logic [W-1:0]       result;
  logic               busy;

  modport master (
    output req, op, a_in, b_in,
    input  gnt, done, done_id, result, busy
  );

  modport slave (
    input  req, op, a_in, b_in,
    output gnt, done, done_id, result, busy
  );
endinterface

// File: rtl/gate_op_arbiter.sv
// gate_op_arbiter: round-robin arbiter in front of a bitwise logic unit that
// is built from 2-input NAND gates. One operation is in flight at a time.
// Each operation takes 3 cycles: IDLE (sample) -> EXEC (gnt) -> DONE (done).
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        gate_op_arbiter_if.slave (req/op/a_in/b_in in, gnt/done/... out)
//   state_dbg  current FSM state (0 IDLE, 1 EXEC, 2 DONE)
module gate_op_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  gate_op_arbiter_if.slave   bus,
  output logic [1:0]         state_dbg
);
  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] win_id;
  logic [1:0]      op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    result_q;
  logic [ID_W-1:0] done_id_q;

  // Round-robin pick
  logic            found;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] idx;
  logic [ID_W-1:0] ptr_inc;
  logic [1:0]      sel_op;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;

  // The search starts at ptr and wraps. The first high req bit wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % N_REQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    ptr_inc = (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
  end

  // Winner operand mux (constant slices only)
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == ID_W'(i)) begin
        sel_op = bus.op[2*i +: 2];
        sel_a  = bus.a_in[W*i +: W];
        sel_b  = bus.b_in[W*i +: W];
      end
    end
  end

  // NAND-only logic unit
  function automatic logic [W-1:0] nand2(input logic [W-1:0] x, input logic [W-1:0] y);
    return ~(x & y);
  endfunction

  logic [W-1:0] na, nb, nab, f;

  always_comb begin
    na  = nand2(a_q, a_q);
    nb  = nand2(b_q, b_q);
    nab = nand2(a_q, b_q);
    f   = '0;
    case (op_q)
      2'b00:   f = nand2(na, nb);    // OR
      2'b01:   f = nand2(nab, nab);  // AND
      2'b10:   f = na;               // NOT a
      default: f = nab;              // NAND
    endcase
  end

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      win_id    <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      done_id_q <= '0;
    end else begin
      if (state == IDLE && found) begin
        win_id <= win;
        op_q   <= sel_op;
        a_q    <= sel_a;
        b_q    <= sel_b;
        ptr    <= ptr_inc;
      end
      if (state == EXEC) begin
        result_q  <= f;
        done_id_q <= win_id;
      end
    end
  end

  // Outputs are decoded from state. Because state resets asynchronously,
  // gnt, done and busy drop as soon as rst_n goes low.
  always_comb begin
    bus.gnt     = '0;
    bus.done    = 1'b0;
    bus.busy    = (state != IDLE);
    bus.done_id = done_id_q;
    bus.result  = result_q;
    if (state == EXEC) bus.gnt  = N_REQ'(1) << win_id;
    if (state == DONE) bus.done = 1'b1;
  end

  assign state_dbg = state;
endmodule

// File: tb/tb_gate_op_arbiter.sv
module tb_gate_op_arbiter;
  localparam int N_REQ = 4;
  localparam int W     = 8;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;

  gate_op_arbiter_if #(.N_REQ(N_REQ), .W(W)) bus ();

  gate_op_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: transaction level
  int           m_phase;   // 0 idle, 1 grant cycle, 2 done cycle
  int           m_ptr;
  int           m_win;
  int           m_id;
  logic [W-1:0] m_result;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (o)
      2'b00:   return a | b;
      2'b01:   return a & b;
      2'b10:   return ~a;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic void model_reset();
    m_phase  = 0;
    m_ptr    = 0;
    m_win    = 0;
    m_id     = 0;
    m_result = '0;
    exp_q.delete();
  endfunction

  // Advance one clock. The model consumes the inputs as they are at the edge,
  // then every output is compared 1 time unit after the edge.
  task automatic tick();
    int w;
    logic [N_REQ-1:0] exp_gnt;
    case (m_phase)
      0: begin
        w = -1;
        for (int k = 0; k < N_REQ; k++) begin
          int i;
          i = (m_ptr + k) % N_REQ;
          if (w < 0 && bus.req[i]) w = i;
        end
        if (w >= 0) begin
          m_win = w;
          m_ptr = (w + 1) % N_REQ;
          exp_q.push_back(ref_op(bus.op[2*w +: 2], bus.a_in[W*w +: W], bus.b_in[W*w +: W]));
          m_phase = 1;
        end
      end
      1: begin
        m_phase  = 2;
        m_result = exp_q.pop_front();
        m_id     = m_win;
      end
      default: m_phase = 0;
    endcase
    @(posedge clk);
    #1;
    exp_gnt = (m_phase == 1) ? (N_REQ'(1) << m_win) : '0;
    check("gnt",     32'(bus.gnt),     32'(exp_gnt));
    check("done",    32'(bus.done),    32'(m_phase == 2));
    check("busy",    32'(bus.busy),    32'(m_phase != 0));
    check("done_id", 32'(bus.done_id), 32'(m_id));
    check("result",  32'(bus.result),  32'(m_result));
  endtask

  // driver tasks
  task automatic set_op(input int i, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    bus.op[2*i +: 2]   = o;
    bus.a_in[W*i +: W] = a;
    bus.b_in[W*i +: W] = b;
  endtask

  // Asynchronous reset in the middle of the high clock phase.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_gnt",     32'(bus.gnt),     32'd0);
    check("rst_done",    32'(bus.done),    32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_result",  32'(bus.result),  32'd0);
    check("rst_done_id", 32'(bus.done_id), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] ops[4];
    logic [W-1:0] exp_res[4];
    ops     = '{2'b00, 2'b01, 2'b10, 2'b11};
    exp_res = '{8'hDB, 8'h42, 8'h3C, 8'hBD};

    rst_n    = 1'b0;
    bus.req  = '0;
    bus.op   = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    model_reset();
    #1;
    check("init_gnt",  32'(bus.gnt),    32'd0);
    check("init_busy", 32'(bus.busy),   32'd0);
    check("init_res",  32'(bus.result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single op on requester 0
    set_op(0, 2'b00, 8'hA5, 8'h0F);
    bus.req = 4'b0001;
    tick();
    check("single_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    tick();
    check("single_done", 32'(bus.done),   32'd1);
    check("single_res",  32'(bus.result), 32'hAF);
    tick();
    check("single_busy", 32'(bus.busy), 32'd0);

    // All ops on requester 2
    for (int o = 0; o < 4; o++) begin
      set_op(2, ops[o], 8'hC3, 8'h5A);
      bus.req = 4'b0100;
      tick();
      check("ops_gnt", 32'(bus.gnt), 32'h4);
      bus.req = '0;
      tick();
      check("ops_res", 32'(bus.result), 32'(exp_res[o]));
      check("ops_id",  32'(bus.done_id), 32'd2);
      tick();
    end

    // Round robin with all requesting
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_op(i, 2'b11, 8'(i), 8'hFF);
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      check("rr_gnt", 32'(bus.gnt), 32'(1 << (g % 4)));
      tick();
      check("rr_done", 32'(bus.done), 32'd1);
      tick();
    end
    bus.req = '0;
    // ptr is now 1. A lone grant of requester 2 moves it to 3.
    bus.req = 4'b0100;
    tick(); tick(); tick();

    // Wrap and skip: ptr=3, req=0101
    bus.req = 4'b0101;
    tick();
    check("wrap_gnt0", 32'(bus.gnt), 32'h1);
    tick(); tick();
    tick();
    check("wrap_gnt2", 32'(bus.gnt), 32'h4);
    tick(); tick();
    bus.req = '0;
    tick();

    // Operands change in the gnt cycle
    set_op(1, 2'b01, 8'hFF, 8'h00);
    bus.req = 4'b0010;
    tick();
    check("chg_gnt", 32'(bus.gnt), 32'h2);
    bus.a_in[W*1 +: W] = 8'h00;
    bus.req = '0;
    tick();
    check("chg_res_and", 32'(bus.result), 32'h00);
    tick(); tick(); tick();
    set_op(1, 2'b00, 8'hF0, 8'h0F);
    bus.req = 4'b0010;
    tick();
    set_op(1, 2'b01, 8'h00, 8'h00);
    bus.req = '0;
    tick();
    check("chg_res_or", 32'(bus.result), 32'hFF);
    tick();

    // Reset during EXEC
    set_op(0, 2'b00, 8'h12, 8'h34);
    bus.req = 4'b0001;
    tick();
    check("mid_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    do_reset();
    for (int c = 0; c < 4; c++) tick();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int i;
        i = $urandom_range(0, N_REQ - 1);
        bus.req[i] = 1'($urandom_range(0, 1));
        set_op(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      end
      if (c == 300) do_reset();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gate_op_arbiter.md
GATE_OP_ARBITER -- requirements
Module: gate_op_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter W, default 8, operand/result width in bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  N_REQ  per-requester request level; bit i = requester i.
REQ-006 op  input  2*N_REQ  op code of requester i at bits [2i+1:2i]: 00 OR, 01 AND, 10 NOT(a), 11 NAND.
REQ-007 a_in  input  W*N_REQ  operand A of requester i at bits [W*i+W-1:W*i].
REQ-008 b_in  input  W*N_REQ  operand B of requester i, same packing; ignored for NOT.
REQ-009 gnt  output  N_REQ  one-hot grant; the granted requester's bit is high for exactly one cycle.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 done_id  output  clog2(N_REQ)  index of the requester whose result is on result.
REQ-012 result  output  W  registered result, held until the next done.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states IDLE, EXEC, DONE; encoding is free.
REQ-015 IDLE: if any req bit is high at a rising edge, latch the winner index, op, a_in and b_in of the winner, then go to EXEC; otherwise stay in IDLE.
REQ-016 Winner selection is round-robin: the search starts at pointer ptr and moves upward with wrap-around, and the first high req bit wins.
REQ-017 On each grant, ptr becomes (winner+1) mod N_REQ; ptr does not change without a grant.
REQ-018 EXEC lasts one cycle: gnt[winner]=1 and every other gnt bit=0; on the next edge, result is loaded with f(op,a,b) and the FSM goes to DONE.
REQ-019 DONE lasts one cycle: done=1 and done_id=winner; on the next edge the FSM returns to IDLE.
REQ-020 Latency: req sampled at edge k; gnt is high for the cycle after edge k; done is high for the cycle after edge k+1; the next request is sampled no earlier than edge k+3 (period of 3 cycles).
REQ-021 Operands are latched at the grant edge; changes to req, op, a_in or b_in after that edge do not affect the result in progress.
REQ-022 The logic unit is bitwise, with width W, and is built only from 2-input nand primitives:
- OR = nand(nand(a,a), nand(b,b))
- AND = nand(nand(a,b), nand(a,b))
- NOT = nand(a,a)
- NAND = nand(a,b)
REQ-023 A requester must hold req, op and operands stable until it sees its gnt bit; it may deassert req in the gnt cycle or later.
REQ-024 If a requester's req is still high when the FSM is next in IDLE, that requester is a new request and competes under round-robin.
REQ-025 If req drops before it is granted, no grant or done is issued for it.
REQ-026 Only one operation is in flight at a time; req changes during EXEC or DONE have no effect on the operation in progress.
REQ-027 gnt is all zero outside EXEC; done is 0 outside DONE.
REQ-028 result and done_id hold their values outside DONE until the next DONE.

Reset
REQ-029 Asserting rst_n low forces, immediately and at any state including mid-operation, the following: state=IDLE, ptr=0, gnt=0, done=0, done_id=0, result=0, busy=0.
REQ-030 An operation interrupted by reset is dropped: it produces no done and restarts only if its req is still high after reset.
REQ-031 The first sampling edge after rst_n deasserts behaves as IDLE with ptr=0.

Verification
REQ-032 Single op: after reset, req=0001, op0=00, a0=8'hA5, b0=8'h0F -> gnt=0001 for 1 cycle at k+1, then done=1, done_id=0, result=8'hAF at k+2, then busy=0.
REQ-033 All ops, requester 2, with a=8'hC3, b=8'h5A:
- OR gives 8'hDB
- AND gives 8'h42
- NOT gives 8'h3C
- NAND gives 8'hBD
REQ-034 Round-robin: with req=1111 held constant, the grant order is 0,1,2,3,0; each done is 3 cycles apart.
REQ-035 Wrap and skip: with ptr=3 and req=0101, requester 0 is granted, then ptr=1, then requester 2 is granted.
REQ-036 Operand change: requester 1 grants with a1=8'hFF, b1=8'h00, op=AND, and a1 is changed to 8'h00 in the gnt cycle -> result=8'h00 from the latched values, with no re-grant if req1 drops.
REQ-037 Reset mid-op: rst_n is pulsed low during EXEC -> gnt, done and busy go to 0 at once; no done pulse is seen; after release with req=0000, the FSM stays IDLE.
